// File: rtl/cpu_pkg.sv
// Shared CPU definitions: operand width, multiplier iteration count, opcode set,
// execute-stage FSM states and the registered EX/MEM bundle layout.
package cpu_pkg;

    localparam int DATA_W   = 8;
    localparam int MUL_ITER = 8;
    localparam logic [2:0] MUL_LAST = 3'(MUL_ITER - 1);

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_XOR   = 4'h4,
        OP_SHL   = 4'h5,
        OP_SHR   = 4'h6,
        OP_MUL   = 4'h7,
        OP_LD    = 4'h8,
        OP_ST    = 4'h9,
        OP_BEQ   = 4'hA,
        OP_BLT   = 4'hB,
        OP_MOV   = 4'hC,
        OP_NOP_D = 4'hD,
        OP_NOP_E = 4'hE,
        OP_NOP_F = 4'hF
    } opcode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ex_state_e;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] store_data;
        logic              wr_mem;
        logic              rd_mem;
        logic              zero;
        logic              carry;
        logic              br_taken;
        logic [DATA_W-1:0] br_target;
    } ex_out_t;

    function automatic logic is_nop(input opcode_e op);
        return (op == OP_NOP_D) || (op == OP_NOP_E) || (op == OP_NOP_F);
    endfunction

    // Ops that finish in one cycle and produce a live EX/MEM bundle.
    function automatic logic is_single(input opcode_e op);
        return !is_nop(op) && (op != OP_MUL);
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// REG/ALU -> EX -> EX/MEM signal bundle; master is the upstream pipeline side,
// slave is the execute stage.
import cpu_pkg::*;

interface ex_stage_if;
    logic              validIn;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] labelValue;
    logic [DATA_W-1:0] regA;
    logic [DATA_W-1:0] regB;
    logic              labelFlag;
    logic              writeMemFlag;
    logic              readMemFlag;
    logic              immediateFlag;
    logic              signFlag;
    logic              flush;

    logic              stall;
    logic              validOut;
    logic [DATA_W-1:0] resultOut;
    logic [DATA_W-1:0] storeDataOut;
    logic              writeMemFlagOut;
    logic              readMemFlagOut;
    logic              zeroOut;
    logic              carryOut;
    logic              branchTaken;
    logic [DATA_W-1:0] branchTarget;

    modport master (
        output validIn, opcode, value, labelValue, regA, regB,
               labelFlag, writeMemFlag, readMemFlag, immediateFlag, signFlag, flush,
        input  stall, validOut, resultOut, storeDataOut, writeMemFlagOut,
               readMemFlagOut, zeroOut, carryOut, branchTaken, branchTarget
    );

    modport slave (
        input  validIn, opcode, value, labelValue, regA, regB,
               labelFlag, writeMemFlag, readMemFlag, immediateFlag, signFlag, flush,
        output stall, validOut, resultOut, storeDataOut, writeMemFlagOut,
               readMemFlagOut, zeroOut, carryOut, branchTaken, branchTarget
    );
endinterface

// File: rtl/mul_seq.sv
// Shift-add multiplier datapath: the first partial product is taken on start,
// then one more per busy cycle; done once no multiplier bits remain.
import cpu_pkg::*;

module mul_seq (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_busy,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_done,
    output logic [DATA_W-1:0] o_product
);

    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [DATA_W-1:0] r_acc;

    // Multiplicand shifts left, multiplier shifts right, accumulator sums partial products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= 8'h00;
            r_mplier <= 8'h00;
            r_acc    <= 8'h00;
        end else if (i_start) begin
            r_acc    <= i_b[0] ? i_a : 8'h00;
            r_mcand  <= i_a << 1;
            r_mplier <= i_b >> 1;
        end else if (i_busy) begin
            r_acc    <= r_mplier[0] ? (r_acc + r_mcand) : r_acc;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end else begin
            r_acc    <= r_acc;
            r_mcand  <= r_mcand;
            r_mplier <= r_mplier;
        end
    end

    assign o_done    = (r_mplier == 8'h00);
    assign o_product = r_acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU/branch/address ops plus a multi-cycle MUL
// sequenced by an IDLE/BUSY FSM that stalls the upstream REG/ALU register.
import cpu_pkg::*;

module ex_stage (
    input  logic     clk,
    input  logic     rst_n,
    ex_stage_if.slave bus
);

    opcode_e           w_op;
    logic [DATA_W-1:0] w_op_b;
    logic [2:0]        w_shamt;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_addr;
    logic [DATA_W-1:0] w_sra;
    logic              w_lt;
    ex_out_t           w_alu;

    ex_state_e         r_state;
    ex_state_e         w_state_nxt;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_nxt;
    ex_out_t           r_out;
    ex_out_t           w_out_nxt;

    logic              w_mul_start;
    logic              w_mul_step;
    logic              w_mul_done;
    logic              w_mul_last;
    logic [DATA_W-1:0] w_mul_product;

    assign w_op    = opcode_e'(bus.opcode);
    assign w_op_b  = bus.immediateFlag ? bus.value : bus.regB;
    assign w_shamt = w_op_b[2:0];
    assign w_sum   = {1'b0, bus.regA} + {1'b0, w_op_b};
    assign w_diff  = {1'b0, bus.regA} - {1'b0, w_op_b};
    assign w_addr  = bus.regA + bus.value;
    assign w_sra   = $unsigned($signed(bus.regA) >>> w_shamt);
    // Branch compare always uses regB, never the immediate.
    assign w_lt    = bus.signFlag ? ($signed(bus.regA) < $signed(bus.regB))
                                  : (bus.regA < bus.regB);

    // Single-cycle result bundle for the instruction currently presented.
    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD: begin
                w_alu.result = w_sum[DATA_W-1:0];
                w_alu.carry  = w_sum[DATA_W];
            end
            OP_SUB: begin
                w_alu.result = w_diff[DATA_W-1:0];
                w_alu.carry  = w_diff[DATA_W];
            end
            OP_AND:  w_alu.result = bus.regA & w_op_b;
            OP_OR:   w_alu.result = bus.regA | w_op_b;
            OP_XOR:  w_alu.result = bus.regA ^ w_op_b;
            OP_SHL:  w_alu.result = bus.regA << w_shamt;
            OP_SHR:  w_alu.result = bus.signFlag ? w_sra : (bus.regA >> w_shamt);
            OP_MUL:  w_alu.result = 8'h00;
            OP_LD, OP_ST: begin
                w_alu.result     = w_addr;
                w_alu.store_data = bus.regB;
            end
            OP_BEQ: begin
                w_alu.br_taken  = bus.labelFlag && (bus.regA == bus.regB);
                w_alu.br_target = bus.labelValue;
            end
            OP_BLT: begin
                w_alu.br_taken  = bus.labelFlag && w_lt;
                w_alu.br_target = bus.labelValue;
            end
            OP_MOV:  w_alu.result = w_op_b;
            default: w_alu.result = 8'h00;
        endcase
        if (is_single(w_op)) begin
            w_alu.valid  = 1'b1;
            w_alu.wr_mem = bus.writeMemFlag;
            w_alu.rd_mem = bus.readMemFlag;
            w_alu.zero   = (w_alu.result == 8'h00);
        end else begin
            w_alu = '0;
        end
    end

    assign w_mul_last = (r_state == ST_BUSY) && (r_cnt == MUL_LAST) && w_mul_done;
    assign w_mul_step = (r_state == ST_BUSY) && !bus.flush;
    assign bus.stall  = ((r_state == ST_IDLE) && bus.validIn && (w_op == OP_MUL)) ||
                        ((r_state == ST_BUSY) && (r_cnt != MUL_LAST));

    // Next state, counter and EX/MEM bundle; flush overrides completion and accept.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = '0;
        w_mul_start = 1'b0;
        if (bus.flush) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.validIn && (w_op == OP_MUL)) begin
                        w_state_nxt = ST_BUSY;
                        w_cnt_nxt   = 3'd0;
                        w_mul_start = 1'b1;
                    end else if (bus.validIn) begin
                        w_out_nxt = w_alu;
                    end else begin
                        w_out_nxt = '0;
                    end
                end
                ST_BUSY: begin
                    if (w_mul_last) begin
                        w_state_nxt      = ST_IDLE;
                        w_cnt_nxt        = 3'd0;
                        w_out_nxt.valid  = 1'b1;
                        w_out_nxt.result = w_mul_product;
                        w_out_nxt.zero   = (w_mul_product == 8'h00);
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    // FSM state and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // EX/MEM output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= w_out_nxt;
        end
    end

    mul_seq u_mul_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_mul_start),
        .i_busy    (w_mul_step),
        .i_a       (bus.regA),
        .i_b       (w_op_b),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );

    assign bus.validOut        = r_out.valid;
    assign bus.resultOut       = r_out.result;
    assign bus.storeDataOut    = r_out.store_data;
    assign bus.writeMemFlagOut = r_out.wr_mem;
    assign bus.readMemFlagOut  = r_out.rd_mem;
    assign bus.zeroOut         = r_out.zero;
    assign bus.carryOut        = r_out.carry;
    assign bus.branchTaken     = r_out.br_taken;
    assign bus.branchTarget    = r_out.br_target;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized traffic
// compared against an arithmetic reference model of the execute stage.
module tb_ex_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_stage_if bus();

    ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: edges left until the MUL result appears, and its product.
    int busy_left = 0;
    int mul_prod  = 0;
    bit last_stall = 1'b0;
    int e_valid, e_result, e_zero, e_carry, e_taken, e_target, e_wr, e_rd, e_store;
    bit e_store_chk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input int op, input int val, input int lbl,
                         input int a, input int b, input bit lf, input bit imm, input bit sgn);
        bus.validIn       = v;
        bus.opcode        = 4'(op);
        bus.value         = 8'(val);
        bus.labelValue    = 8'(lbl);
        bus.regA          = 8'(a);
        bus.regB          = 8'(b);
        bus.labelFlag     = lf;
        bus.immediateFlag = imm;
        bus.signFlag      = sgn;
        bus.readMemFlag   = (op == 8);
        bus.writeMemFlag  = (op == 9);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_validOut"}, bus.validOut, 0);
        check_val({tag, "_resultOut"}, bus.resultOut, 0);
        check_val({tag, "_storeData"}, bus.storeDataOut, 0);
        check_val({tag, "_wrMem"}, bus.writeMemFlagOut, 0);
        check_val({tag, "_rdMem"}, bus.readMemFlagOut, 0);
        check_val({tag, "_zero"}, bus.zeroOut, 0);
        check_val({tag, "_carry"}, bus.carryOut, 0);
        check_val({tag, "_branchTaken"}, bus.branchTaken, 0);
        check_val({tag, "_branchTarget"}, bus.branchTarget, 0);
    endtask

    // One clock: check stall, predict the EX/MEM bundle, clock, compare.
    task automatic step();
        int a, b, v, op, opb, sh, sa, sb, r;
        bit exp_st, lt;
        #1;
        a   = int'(bus.regA);
        b   = int'(bus.regB);
        v   = int'(bus.value);
        op  = int'(bus.opcode);
        opb = bus.immediateFlag ? v : b;
        sh  = opb % 8;
        sa  = (a >= 128) ? a - 256 : a;
        sb  = (b >= 128) ? b - 256 : b;
        exp_st = (busy_left > 1) || (busy_left == 0 && bus.validIn && op == 7);
        check_val("stall", bus.stall, exp_st);
        last_stall = exp_st;
        e_valid = 0; e_result = 0; e_zero = 0; e_carry = 0; e_taken = 0;
        e_target = 0; e_wr = 0; e_rd = 0; e_store = 0; e_store_chk = 0;
        if (bus.flush) begin
            busy_left = 0;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                e_valid  = 1;
                e_result = mul_prod;
                e_zero   = (mul_prod == 0);
            end
        end else if (bus.validIn && op == 7) begin
            busy_left = 8;
            mul_prod  = (a * opb) % 256;
        end else if (bus.validIn && op <= 12) begin
            r = 0;
            case (op)
                0:  begin r = a + opb; e_carry = (r > 255); end
                1:  begin r = a - opb; e_carry = (a < opb); end
                2:  r = a & opb;
                3:  r = a | opb;
                4:  r = a ^ opb;
                5:  r = a << sh;
                6:  r = bus.signFlag ? (sa >>> sh) : (a >> sh);
                8, 9: begin r = a + v; e_store = b; e_store_chk = 1; end
                10: begin e_taken = bus.labelFlag && (a == b); e_target = int'(bus.labelValue); end
                11: begin
                    lt = bus.signFlag ? (sa < sb) : (a < b);
                    e_taken = bus.labelFlag && lt;
                    e_target = int'(bus.labelValue);
                end
                default: r = opb;
            endcase
            e_valid  = 1;
            e_result = r & 255;
            e_zero   = (e_result == 0);
            e_wr     = bus.writeMemFlag;
            e_rd     = bus.readMemFlag;
        end
        @(posedge clk);
        #1;
        check_val("validOut", bus.validOut, e_valid);
        check_val("branchTaken", bus.branchTaken, e_taken);
        check_val("writeMemFlagOut", bus.writeMemFlagOut, e_wr);
        check_val("readMemFlagOut", bus.readMemFlagOut, e_rd);
        if (e_valid) begin
            check_val("resultOut", bus.resultOut, e_result);
            check_val("zeroOut", bus.zeroOut, e_zero);
            check_val("carryOut", bus.carryOut, e_carry);
        end
        if (e_store_chk) check_val("storeDataOut", bus.storeDataOut, e_store);
        if (e_taken) check_val("branchTarget", bus.branchTarget, e_target);
    endtask

    task automatic randomize_inputs();
        int op, a, b;
        op = $urandom_range(0, 15);
        a  = $urandom_range(0, 255);
        b  = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, 255);
        drive($urandom_range(0, 4) != 0, op, $urandom_range(0, 255), $urandom_range(0, 255),
              a, b, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    endtask

    initial begin
        bus.flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        @(posedge clk);
        #1;
        check_all_zero("reset");
        check_val("reset_stall", bus.stall, 0);
        #2 rst_n = 1'b1;

        // ADD with carry out
        drive(1, 0, 0, 0, 8'hF0, 8'h20, 0, 0, 0);
        step();
        check_val("add_result", bus.resultOut, 8'h10);
        check_val("add_carry", bus.carryOut, 1);

        // SUB immediate to zero
        drive(1, 1, 8'h05, 0, 8'h05, 8'h77, 0, 1, 0);
        step();
        check_val("sub_zero", bus.zeroOut, 1);

        // MUL held under stall: 8 stall cycles, result on the 9th edge
        begin
            int stall_cnt = 0;
            drive(1, 7, 0, 0, 8'h0D, 8'h0B, 0, 0, 0);
            for (int i = 0; i < 9; i++) begin
                step();
                if (last_stall) stall_cnt++;
            end
            check_val("mul_stall_cycles", stall_cnt, 8);
            check_val("mul_result", bus.resultOut, 8'h8F);
        end

        // BLT signed vs unsigned
        drive(1, 11, 0, 8'h5A, 8'hFF, 8'h01, 1, 0, 1);
        step();
        check_val("blt_signed_taken", bus.branchTaken, 1);
        check_val("blt_target", bus.branchTarget, 8'h5A);
        drive(1, 11, 0, 8'h5A, 8'hFF, 8'h01, 1, 0, 0);
        step();
        check_val("blt_unsigned_taken", bus.branchTaken, 0);

        // Flush at counter 4 kills the MUL
        drive(1, 7, 0, 0, 8'h33, 8'h05, 0, 0, 0);
        for (int i = 0; i < 5; i++) step();
        bus.flush = 1'b1;
        bus.validIn = 1'b0;
        step();
        bus.flush = 1'b0;
        #1;
        check_val("flush_stall", bus.stall, 0);
        for (int i = 0; i < 4; i++) step();

        // Reset at counter 3 abandons the MUL; ADD afterwards completes
        drive(1, 7, 0, 0, 8'h0F, 8'h0F, 0, 0, 0);
        for (int i = 0; i < 4; i++) step();
        #2;
        bus.validIn = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("midmul_reset");
        check_val("midmul_reset_stall", bus.stall, 0);
        busy_left = 0;
        #1 rst_n = 1'b1;
        drive(1, 0, 0, 0, 8'h01, 8'h02, 0, 0, 0);
        step();
        check_val("post_reset_add", bus.resultOut, 8'h03);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step();

        // Randomized traffic; upstream holds its register while stall is high
        for (int i = 0; i < 1500; i++) begin
            if (!last_stall) randomize_inputs();
            bus.flush = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
